pipeline_hazard_ctrl: RTL and testbench

- Central hazard controller for the 5-stage RISC-V pipeline.
- Tracks destination/source register tags of instructions in the EX, MEM and WB stages with its own shadow pipeline.
- Generates pipeline register enables, flushes and bubbles for load-use hazards, taken branches/jumps and data-memory wait.
- Generates EX-stage operand forwarding selects, and keeps a performance counter of load-use stall cycles.

---
 rtl/pipeline_hazard_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// ---------------------------------------------------------------------------
// Central hazard controller for a 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
// A small shadow pipeline mirrors the register tags of the instructions in
// EX, MEM and WB. From these tags and the current ID instruction the block
// derives the pipeline register enables, the IF/ID flush, the ID/EX bubble,
// and the EX-stage operand forwarding selects. It also counts load-use
// stall cycles.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   id_*               decoded fields of the instruction currently in ID
//   ex_redirect        branch taken / jump resolved in EX (flush younger)
//   dmem_busy          data memory not ready: freeze the whole pipeline
//   pc_en, if_id_en    front-end enables (dropped on stall or freeze)
//   if_id_flush        clear IF/ID to NOP on redirect
//   id_ex_bubble       load a NOP into ID/EX (redirect or load-use)
//   ex_mem_en          EX/MEM enable (dropped only on freeze)
//   mem_wb_en          MEM/WB enable (dropped only on freeze)
//   fwd_a_sel/_b_sel   EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   load_use_stall     a load-use stall cycle is being inserted now
//   stall_cnt          running count of load-use stall cycles (wraps)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_write_en,
  input  logic                      id_is_load,
  input  logic                      ex_redirect,
  input  logic                      dmem_busy,
  output logic                      pc_en,
  output logic                      if_id_en,
  output logic                      if_id_flush,
  output logic                      id_ex_bubble,
  output logic                      ex_mem_en,
  output logic                      mem_wb_en,
  output logic [1:0]                fwd_a_sel,
  output logic [1:0]                fwd_b_sel,
  output logic                      load_use_stall,
  output logic [CNT_WIDTH-1:0]      stall_cnt
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_X0 = '0;

  // -------------------------------------------------------------------------
  // Shadow pipeline. Only valid bits are reset; the tag fields are don't-care
  // whenever the matching valid bit is low, and every consumer gates on it.
  // WB forwards load data and ALU data alike, so WB needs no load bit.
  // -------------------------------------------------------------------------
  logic                      ex_valid_reg;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_reg;
  logic                      ex_we_reg;
  logic                      ex_load_reg;
  logic [REG_ADDR_WIDTH-1:0] ex_rs1_reg;
  logic [REG_ADDR_WIDTH-1:0] ex_rs2_reg;
  logic                      ex_rs1_used_reg;
  logic                      ex_rs2_used_reg;

  logic                      mem_valid_reg;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_reg;
  logic                      mem_we_reg;
  logic                      mem_load_reg;

  logic                      wb_valid_reg;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_reg;
  logic                      wb_we_reg;

  logic [CNT_WIDTH-1:0]      stall_cnt_reg;

  // -------------------------------------------------------------------------
  // Load-use detection: a load in EX whose result the ID instruction needs.
  // The load data only exists at the end of MEM, so ID must wait one cycle
  // and then pick the value up from MEM/WB.
  // -------------------------------------------------------------------------
  logic ex_is_live_load;
  logic rs1_dep;
  logic rs2_dep;
  logic load_use_hz;

  assign ex_is_live_load = ex_valid_reg && ex_load_reg && ex_we_reg && (ex_rd_reg != REG_X0);
  assign rs1_dep         = id_rs1_used && (id_rs1 == ex_rd_reg);
  assign rs2_dep         = id_rs2_used && (id_rs2 == ex_rd_reg);
  assign load_use_hz     = ex_is_live_load && id_valid && (rs1_dep || rs2_dep);

  // A redirect kills the ID instruction anyway, so any load-use hazard it
  // carries is moot and must not be counted.
  logic stall_take;
  logic insert_bubble;

  assign stall_take    = load_use_hz && !ex_redirect;
  assign insert_bubble = ex_redirect || load_use_hz;

  // -------------------------------------------------------------------------
  // Pipeline control. Purely combinational so redirect and busy act on the
  // enables in the same cycle they arrive.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_en          = 1'b1;
    if_id_en       = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    ex_mem_en      = 1'b1;
    mem_wb_en      = 1'b1;
    load_use_stall = 1'b0;
    if (reset) begin
      // Pipeline runs freely while being reset; nothing is stalled.
    end else if (dmem_busy) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (ex_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use_hz) begin
      pc_en          = 1'b0;
      if_id_en       = 1'b0;
      id_ex_bubble   = 1'b1;
      load_use_stall = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Forwarding. Operand A (rs1) and operand B (rs2) use identical logic, one
  // generate iteration each. MEM wins over WB since it holds the younger
  // result. A load in MEM has no data yet, so it never forwards from MEM.
  // -------------------------------------------------------------------------
  logic [1:0][REG_ADDR_WIDTH-1:0] op_src;
  logic [1:0]                     op_used;
  logic [1:0][1:0]                op_sel;

  assign op_src[0]  = ex_rs1_reg;
  assign op_src[1]  = ex_rs2_reg;
  assign op_used[0] = ex_rs1_used_reg;
  assign op_used[1] = ex_rs2_used_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic op_live;
      logic mem_hit;
      logic wb_hit;

      assign op_live = !reset && ex_valid_reg && op_used[gi];
      assign mem_hit = mem_valid_reg && mem_we_reg && !mem_load_reg &&
                       (mem_rd_reg != REG_X0) && (mem_rd_reg == op_src[gi]);
      assign wb_hit  = wb_valid_reg && wb_we_reg &&
                       (wb_rd_reg != REG_X0) && (wb_rd_reg == op_src[gi]);

      assign op_sel[gi] = !op_live ? FWD_RF  :
                          mem_hit  ? FWD_MEM :
                          wb_hit   ? FWD_WB  : FWD_RF;
    end
  endgenerate

  assign fwd_a_sel = op_sel[0];
  assign fwd_b_sel = op_sel[1];
  assign stall_cnt = stall_cnt_reg;

  // -------------------------------------------------------------------------
  // Shadow pipeline advance and stall counter. A busy data memory freezes
  // everything, including the counter, so a stall that is pending under the
  // freeze is counted once, on the cycle it is actually taken.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_reg  <= 1'b0;
      mem_valid_reg <= 1'b0;
      wb_valid_reg  <= 1'b0;
      stall_cnt_reg <= '0;
    end else if (!dmem_busy) begin
      wb_valid_reg    <= mem_valid_reg;
      wb_rd_reg       <= mem_rd_reg;
      wb_we_reg       <= mem_we_reg;

      mem_valid_reg   <= ex_valid_reg;
      mem_rd_reg      <= ex_rd_reg;
      mem_we_reg      <= ex_we_reg;
      mem_load_reg    <= ex_load_reg;

      // Tag fields follow ID unconditionally; only the valid bit decides
      // whether EX holds a real instruction or a bubble.
      ex_valid_reg    <= id_valid && !insert_bubble;
      ex_rd_reg       <= id_rd;
      ex_we_reg       <= id_reg_write_en;
      ex_load_reg     <= id_is_load;
      ex_rs1_reg      <= id_rs1;
      ex_rs2_reg      <= id_rs2;
      ex_rs1_used_reg <= id_rs1_used;
      ex_rs2_used_reg <= id_rs2_used;

      if (stall_take) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios from the test plan
// followed by randomized traffic compared against an instruction-level model.
module tb_pipeline_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 32;

  // Control vector layout: {pc, if_id, flush, bubble, ex_mem, mem_wb, stall}
  localparam logic [6:0] CTL_RUN    = 7'b1100110;
  localparam logic [6:0] CTL_FREEZE = 7'b0000000;
  localparam logic [6:0] CTL_REDIR  = 7'b1111110;
  localparam logic [6:0] CTL_LU     = 7'b0001111;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic          we;
    logic          ld;
  } instr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_redirect;
  logic          dmem_busy;
  instr_t        id_ins;

  logic          pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          load_use_stall;
  logic [CW-1:0] stall_cnt;
  logic [6:0]    ctl;

  assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en, load_use_stall};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_ins.valid),
    .id_rs1          (id_ins.rs1),
    .id_rs2          (id_ins.rs2),
    .id_rs1_used     (id_ins.u1),
    .id_rs2_used     (id_ins.u2),
    .id_rd           (id_ins.rd),
    .id_reg_write_en (id_ins.we),
    .id_is_load      (id_ins.ld),
    .ex_redirect     (ex_redirect),
    .dmem_busy       (dmem_busy),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .load_use_stall  (load_use_stall),
    .stall_cnt       (stall_cnt)
  );

  // ---------------------------------------------------------------------
  // Reference model: the instructions occupying EX, MEM, WB (index 0,1,2)
  // and the number of load-use stall cycles taken so far.
  // ---------------------------------------------------------------------
  instr_t        m_stage [3] = '{default: '0};
  logic [CW-1:0] m_cnt = '0;

  function automatic logic model_hz();
    instr_t p = m_stage[0];
    if (!(p.valid && p.ld && p.we && p.rd != 0 && id_ins.valid)) return 1'b0;
    return (id_ins.u1 && id_ins.rs1 == p.rd) || (id_ins.u2 && id_ins.rs2 == p.rd);
  endfunction

  // Source for an EX operand: the nearest older instruction (distance 1 =
  // MEM, 2 = WB) that writes that register and has its value ready.
  function automatic logic [1:0] model_fwd(input logic [RW-1:0] src, input logic used);
    if (reset || !m_stage[0].valid || !used) return 2'd0;
    for (int d = 1; d <= 2; d++) begin
      instr_t p = m_stage[d];
      if (p.valid && p.we && p.rd != 0 && p.rd == src && !(d == 1 && p.ld)) return 2'(d);
    end
    return 2'd0;
  endfunction

  task automatic model_advance();
    logic hz;
    if (reset) begin
      for (int i = 0; i < 3; i++) m_stage[i].valid = 1'b0;
      m_cnt = '0;
    end else if (!dmem_busy) begin
      hz = model_hz();
      m_stage[2] = m_stage[1];
      m_stage[1] = m_stage[0];
      m_stage[0] = (ex_redirect || hz) ? instr_t'('0) : id_ins;
      if (hz && !ex_redirect) m_cnt = m_cnt + 1;
    end
  endtask

  // One clock: the model consumes the inputs present at the edge.
  task automatic cycle();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic set_id(input logic v, input int rd, input int rs1, input int rs2,
                        input logic u1, input logic u2, input logic we, input logic ld);
    id_ins.valid = v;
    id_ins.rd    = RW'(rd);
    id_ins.rs1   = RW'(rs1);
    id_ins.rs2   = RW'(rs2);
    id_ins.u1    = u1;
    id_ins.u2    = u2;
    id_ins.we    = we;
    id_ins.ld    = ld;
  endtask

  task automatic set_nop();
    set_id(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    set_nop();
    ex_redirect = 1'b0;
    dmem_busy   = 1'b0;
    repeat (3) cycle();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; ex_redirect = 1'b0; dmem_busy = 1'b0; set_nop();
    cycle(); cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_RUN); end
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL reset_fwd_a got=%b exp=00", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL reset_fwd_b got=%b exp=00", fwd_b_sel); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    cycle();
    $display("test_reset done");
  endtask

  task automatic test_fwd_mem();
    drain();
    set_id(1'b1, 5, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0);   // add x5,x1,x2
    cycle();
    set_id(1'b1, 6, 5, 3, 1'b1, 1'b1, 1'b1, 1'b0);   // sub x6,x5,x3
    cycle();
    set_nop();
    @(negedge clk);
    checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL mem_fwd_a got=%b exp=01", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL mem_fwd_b got=%b exp=00", fwd_b_sel); end
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL mem_fwd_ctl got=%b exp=%b", ctl, CTL_RUN); end
    cycle();
    $display("test_fwd_mem done");
  endtask

  task automatic test_fwd_wb();
    drain();
    set_id(1'b1, 5, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0);   // add x5,x1,x2
    cycle();
    set_nop();
    cycle();
    set_id(1'b1, 7, 4, 5, 1'b1, 1'b1, 1'b1, 1'b0);   // or x7,x4,x5
    cycle();
    set_nop();
    @(negedge clk);
    checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL wb_fwd_b got=%b exp=10", fwd_b_sel); end
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL wb_fwd_a got=%b exp=00", fwd_a_sel); end
    cycle();
    // Writer of x0 two ahead, then directly ahead: never forwards.
    drain();
    set_id(1'b1, 0, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0);   // add x0,x1,x2
    cycle();
    set_nop();
    cycle();
    set_id(1'b1, 7, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);   // or x7,x0,x0
    cycle();
    set_id(1'b1, 0, 3, 3, 1'b1, 1'b1, 1'b1, 1'b0);   // add x0,x3,x3
    @(negedge clk);
    checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin errors++; $display("FAIL x0_wb_fwd got=%b exp=0000", {fwd_a_sel, fwd_b_sel}); end
    cycle();
    set_id(1'b1, 7, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);   // or x7,x0,x0
    cycle();
    set_nop();
    @(negedge clk);
    checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin errors++; $display("FAIL x0_mem_fwd got=%b exp=0000", {fwd_a_sel, fwd_b_sel}); end
    cycle();
    $display("test_fwd_wb done");
  endtask

  task automatic test_load_use();
    logic [CW-1:0] base;
    drain();
    base = m_cnt;
    set_id(1'b1, 8, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1);   // lw x8,0(x1)
    cycle();
    set_id(1'b1, 9, 8, 8, 1'b1, 1'b1, 1'b1, 1'b0);   // add x9,x8,x8
    @(negedge clk);
    checks++; if (ctl !== CTL_LU) begin errors++; $display("FAIL lu_stall_ctl got=%b exp=%b", ctl, CTL_LU); end
    checks++; if (stall_cnt !== base) begin errors++; $display("FAIL lu_cnt_before got=%0d exp=%0d", stall_cnt, base); end
    cycle();
    @(negedge clk);
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_single_stall got=%b exp=%b", ctl, CTL_RUN); end
    checks++; if (stall_cnt !== base + 1) begin errors++; $display("FAIL lu_cnt_after got=%0d exp=%0d", stall_cnt, base + 1); end
    cycle();
    set_nop();
    @(negedge clk);
    checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b1010) begin errors++; $display("FAIL lu_fwd got=%b exp=1010", {fwd_a_sel, fwd_b_sel}); end
    cycle();
    $display("test_load_use done cnt=%0d", stall_cnt);
  endtask

  task automatic test_redirect();
    logic [CW-1:0] base;
    drain();
    base = m_cnt;
    set_id(1'b1, 8, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1);   // lw x8
    cycle();
    set_id(1'b1, 9, 8, 0, 1'b1, 1'b1, 1'b1, 1'b0);   // add x9,x8,x0
    ex_redirect = 1'b1;
    @(negedge clk);
    checks++; if (ctl !== CTL_REDIR) begin errors++; $display("FAIL redir_ctl got=%b exp=%b", ctl, CTL_REDIR); end
    cycle();
    ex_redirect = 1'b0;
    set_nop();
    @(negedge clk);
    checks++; if (stall_cnt !== base) begin errors++; $display("FAIL redir_cnt got=%0d exp=%0d", stall_cnt, base); end
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL redir_after_ctl got=%b exp=%b", ctl, CTL_RUN); end
    cycle();
    $display("test_redirect done");
  endtask

  task automatic test_busy();
    logic [CW-1:0] base;
    drain();
    base = m_cnt;
    set_id(1'b1, 8, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1);   // lw x8
    cycle();
    set_id(1'b1, 9, 8, 8, 1'b1, 1'b1, 1'b1, 1'b0);   // add x9,x8,x8
    dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (ctl !== CTL_FREEZE) begin errors++; $display("FAIL busy_ctl[%0d] got=%b exp=%b", i, ctl, CTL_FREEZE); end
      checks++; if (stall_cnt !== base) begin errors++; $display("FAIL busy_cnt[%0d] got=%0d exp=%0d", i, stall_cnt, base); end
      cycle();
    end
    dmem_busy = 1'b0;
    @(negedge clk);
    checks++; if (ctl !== CTL_LU) begin errors++; $display("FAIL busy_then_stall got=%b exp=%b", ctl, CTL_LU); end
    cycle();
    @(negedge clk);
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL busy_stall_once got=%b exp=%b", ctl, CTL_RUN); end
    checks++; if (stall_cnt !== base + 1) begin errors++; $display("FAIL busy_cnt_after got=%0d exp=%0d", stall_cnt, base + 1); end
    cycle();
    set_nop();
    @(negedge clk);
    checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b1010) begin errors++; $display("FAIL busy_fwd got=%b exp=1010", {fwd_a_sel, fwd_b_sel}); end
    cycle();
    $display("test_busy done");
  endtask

  // Randomized traffic over a small register set so hazards are frequent.
  task automatic test_random();
    logic [6:0] exp_ctl;
    logic [1:0] exp_a, exp_b;
    logic       hz;
    for (int t = 0; t < 300; t++) begin
      reset       = ($urandom_range(0, 49) == 0);
      dmem_busy   = ($urandom_range(0, 6) == 0);
      ex_redirect = ($urandom_range(0, 8) == 0);
      set_id($urandom_range(0, 4) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 5) != 0, $urandom_range(0, 2) == 0);
      @(negedge clk);
      hz = model_hz();
      if (reset)            exp_ctl = CTL_RUN;
      else if (dmem_busy)   exp_ctl = CTL_FREEZE;
      else if (ex_redirect) exp_ctl = CTL_REDIR;
      else if (hz)          exp_ctl = CTL_LU;
      else                  exp_ctl = CTL_RUN;
      exp_a = model_fwd(m_stage[0].rs1, m_stage[0].u1);
      exp_b = model_fwd(m_stage[0].rs2, m_stage[0].u2);
      checks++; if (ctl !== exp_ctl) begin errors++; $display("FAIL rnd_ctl t=%0d got=%b exp=%b", t, ctl, exp_ctl); end
      checks++; if (fwd_a_sel !== exp_a) begin errors++; $display("FAIL rnd_fwd_a t=%0d got=%b exp=%b", t, fwd_a_sel, exp_a); end
      checks++; if (fwd_b_sel !== exp_b) begin errors++; $display("FAIL rnd_fwd_b t=%0d got=%b exp=%b", t, fwd_b_sel, exp_b); end
      checks++; if (stall_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt t=%0d got=%0d exp=%0d", t, stall_cnt, m_cnt); end
      $display("txn %0d rst=%0b busy=%0b redir=%0b ctl=%b fa=%b fb=%b cnt=%0d",
               t, reset, dmem_busy, ex_redirect, ctl, fwd_a_sel, fwd_b_sel, stall_cnt);
      cycle();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ex_redirect = 1'b0; dmem_busy = 1'b0;
    set_nop();
    test_reset();
    test_fwd_mem();
    test_fwd_wb();
    test_load_use();
    test_redirect();
    test_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
